mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the pipelined MIPS datapath.
- Implements MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- Also provides direct HI/LO writes for MTHI/MTLO.
- Sits beside the ALU in EX; the hazard unit stalls on busy and reads hi/lo for MFHI/MFLO.

---
 rtl/mul_div_unit_pkg.sv | 19 +
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit_datapath.sv | 49 ++++
 rtl/mul_div_unit.sv | 108 ++++++++++
 tb/tb_mul_div_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared op/state encodings and op decode helpers
package mul_div_unit_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    function automatic logic is_div(op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed(op_e op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: command, operand and HI/LO bus of the multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
    import mul_div_unit_pkg::*;
    logic             i_start;
    op_e              i_op;
    logic [WIDTH-1:0] i_src_a;
    logic [WIDTH-1:0] i_src_b;
    logic             i_hi_we;
    logic             i_lo_we;
    logic [WIDTH-1:0] i_hi_wdata;
    logic [WIDTH-1:0] i_lo_wdata;
    logic             o_busy;
    logic             o_done;
    logic             o_div_by_zero;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_src_a, i_src_b, i_hi_we, i_lo_we, i_hi_wdata, i_lo_wdata,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_src_a, i_src_b, i_hi_we, i_lo_we, i_hi_wdata, i_lo_wdata,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/mul_div_unit_datapath.sv
// md_datapath: shared accumulator for shift-add multiply and restoring divide on magnitudes
module md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_rem,
    output logic [WIDTH-1:0]   o_quo
);
    // r_acc = {partial remainder / product high, quotient / multiplier bits}
    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_d;
    logic [2*WIDTH:0] w_mul, w_dvs;
    logic [WIDTH:0]   w_sum, w_shift;
    logic [WIDTH+1:0] w_diff;

    // One radix-2 step: conditional add-then-shift, or shift-then-trial-subtract
    always_comb begin
        w_sum   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_d} : '0);
        w_mul   = {1'b0, w_sum, r_acc[WIDTH-1:1]};
        w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b0, r_d};
        w_dvs   = w_diff[WIDTH+1] ? {w_shift, r_acc[WIDTH-2:0], 1'b0}
                                  : {w_diff[WIDTH:0], r_acc[WIDTH-2:0], 1'b1};
    end

    // Load operands at start, then advance one step per CALC cycle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= '0;
            r_d   <= '0;
        end else if (i_load) begin
            r_acc <= {{(WIDTH+1){1'b0}}, i_a};
            r_d   <= i_b;
        end else if (i_step) begin
            r_acc <= i_div ? w_dvs : w_mul;
        end
    end

    assign o_prod = r_acc[2*WIDTH-1:0];
    assign o_rem  = r_acc[2*WIDTH-1:WIDTH];
    assign o_quo  = r_acc[WIDTH-1:0];
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
module mul_div_unit import mul_div_unit_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          i_clock,
    input logic          i_reset,
    mul_div_unit_if.slave bus
);
    state_e             r_state, w_next;
    op_e                r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q, r_neg_r, r_b_zero, r_done, r_dbz;
    logic [WIDTH-1:0]   r_a_orig, r_hi, r_lo;
    logic               w_idle, w_load, w_sa, w_sb;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_quo_s, w_rem_s;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;

    assign w_idle  = r_state == S_IDLE;
    assign w_load  = w_idle & bus.i_start;
    assign w_sa    = is_signed(bus.i_op) & bus.i_src_a[WIDTH-1];
    assign w_sb    = is_signed(bus.i_op) & bus.i_src_b[WIDTH-1];
    assign w_mag_a = w_sa ? -bus.i_src_a : bus.i_src_a;
    assign w_mag_b = w_sb ? -bus.i_src_b : bus.i_src_b;

    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_step  (r_state == S_CALC),
        .i_div   (is_div(r_op)),
        .i_a     (w_mag_a),
        .i_b     (w_mag_b),
        .o_prod  (w_prod),
        .o_rem   (w_rem),
        .o_quo   (w_quo)
    );

    // Next state: fixed-length CALC phase followed by a single FIX cycle
    always_comb begin
        w_next = r_state;
        if (w_load)
            w_next = S_CALC;
        else if (r_state == S_CALC && r_cnt == CNT_W'(1))
            w_next = S_FIX;
        else if (r_state == S_FIX)
            w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Capture operation context at start and count down the iterations
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_op     <= OP_MULT;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_orig <= '0;
        end else if (w_load) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_op     <= bus.i_op;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_b_zero <= bus.i_src_b == '0;
            r_a_orig <= bus.i_src_a;
        end else if (r_state == S_CALC) begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    // Remainder follows the dividend's sign; product and quotient follow the sign XOR
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo_s  = r_neg_q ? -w_quo : w_quo;
    assign w_rem_s  = r_neg_r ? -w_rem : w_rem;

    // Commit results at FIX; MTHI/MTLO only in IDLE and only when not starting
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= r_state == S_FIX;
            r_dbz  <= r_state == S_FIX && is_div(r_op) && r_b_zero;
            if (r_state == S_FIX) begin
                {r_hi, r_lo} <= !is_div(r_op) ? w_prod_s
                              : r_b_zero      ? {r_a_orig, {WIDTH{1'b1}}}
                              :                 {w_rem_s, w_quo_s};
            end else if (w_idle && !bus.i_start) begin
                if (bus.i_hi_we) r_hi <= bus.i_hi_wdata;
                if (bus.i_lo_we) r_lo <= bus.i_lo_wdata;
            end
        end
    end

    assign bus.o_busy        = !w_idle;
    assign bus.o_done        = r_done;
    assign bus.o_div_by_zero = r_dbz;
    assign bus.o_hi          = r_hi;
    assign bus.o_lo          = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: vector table, randomized model comparison and busy/reset corner sequences
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef struct {
        op_e         op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mul_div_unit_if #(.WIDTH(32)) bus();
    mul_div_unit #(.WIDTH(32)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural reference using plain 64-bit arithmetic (SV division truncates toward zero)
    function automatic void model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint sa, sb;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        r   = '0;
        if (op == OP_MULT)
            r = 64'(sa * sb);
        else if (op == OP_MULTU)
            r = {32'b0, a} * {32'b0, b};
        else if (b == 0) begin
            r   = {a, 32'hFFFF_FFFF};
            dbz = 1'b1;
        end else if (op == OP_DIV)
            r = {32'(sa % sb), 32'(sa / sb)};
        else
            r = {a % b, a / b};
        {hi, lo} = r;
    endfunction

    // Called at a negedge: pulses start and returns at the negedge where done is seen
    task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy1);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_src_a = a;
        bus.i_src_b = b;
        lat   = 0;
        busy1 = 1'b0;
        do begin
            @(negedge clk);
            bus.i_start = 1'b0;
            lat++;
            if (lat == 1) busy1 = bus.o_busy;
        end while (!bus.o_done && lat < 100);
    endtask

    task automatic run_check(input string name, input op_e op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int   lat;
        logic busy1;
        do_op(op, a, b, lat, busy1);
        check({name, " latency"}, lat, 34);
        check({name, " busy"}, busy1, 1);
        check({name, " hi"}, bus.o_hi, eh);
        check({name, " lo"}, bus.o_lo, el);
        check({name, " dbz"}, bus.o_div_by_zero, ed);
        check({name, " busy at done"}, bus.o_busy, 0);
    endtask

    initial begin
        vec_t        vt[9];
        int          lat, dones;
        logic [31:0] a, b, eh, el;
        logic        ed;
        op_e         op;

        bus.i_start = 0; bus.i_op = OP_MULT; bus.i_src_a = 0; bus.i_src_b = 0;
        bus.i_hi_we = 0; bus.i_lo_we = 0; bus.i_hi_wdata = 0; bus.i_lo_wdata = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", bus.o_busy, 0);
        check("reset done", bus.o_done, 0);
        check("reset dbz", bus.o_div_by_zero, 0);
        check("reset hi", bus.o_hi, 0);
        check("reset lo", bus.o_lo, 0);
        rst = 1'b0;
        @(negedge clk);

        vt[0] = '{OP_MULTU, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A, 1'b0};
        vt[1] = '{OP_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vt[2] = '{OP_MULTU, 32'hFFFF_FFFD,  32'd5,          32'h0000_0004, 32'hFFFF_FFF1, 1'b0};
        vt[3] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vt[4] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
        vt[5] = '{OP_DIVU,  32'd100,        32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vt[6] = '{OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vt[7] = '{OP_DIV,   32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vt[8] = '{OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
        for (int i = 0; i < 9; i++)
            run_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].dbz);

        for (int i = 0; i < 40; i++) begin
            op = op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            model(op, a, b, eh, el, ed);
            run_check($sformatf("rand%0d op%0d %h/%h", i, op, a, b), op, a, b, eh, el, ed);
        end

        bus.i_hi_we = 1'b1; bus.i_hi_wdata = 32'h5555;
        @(negedge clk);
        bus.i_hi_we = 1'b0;
        check("mthi", bus.o_hi, 32'h5555);

        bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_src_a = 3; bus.i_src_b = 3;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.i_start = (lat == 5);
            if (lat == 5) begin bus.i_src_a = 2; bus.i_src_b = 2; end
            bus.i_hi_we = (lat == 8);
            bus.i_hi_wdata = 32'h1234;
            if (lat == 10) check("hi held while busy", bus.o_hi, 32'h5555);
        end while (!bus.o_done && lat < 100);
        check("ignore start latency", lat, 34);
        check("ignore start lo", bus.o_lo, 9);
        check("ignore start hi", bus.o_hi, 0);

        run_check("back-to-back", OP_MULTU, 7, 6, 0, 32'h2A, 0);

        bus.i_hi_we = 1'b1; bus.i_hi_wdata = 32'hBEEF;
        run_check("start beats mthi", OP_MULTU, 1, 1, 0, 1, 0);
        bus.i_hi_we = 1'b0;

        bus.i_hi_we = 1'b1; bus.i_hi_wdata = 32'hAAAA;
        bus.i_lo_we = 1'b1; bus.i_lo_wdata = 32'hBBBB;
        @(negedge clk);
        bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b0;
        check("mthi/mtlo hi", bus.o_hi, 32'hAAAA);
        check("mthi/mtlo lo", bus.o_lo, 32'hBBBB);

        bus.i_start = 1'b1; bus.i_op = OP_MULTU; bus.i_src_a = 32'hFFFF; bus.i_src_b = 32'hFFFF;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy before reset", bus.o_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset busy", bus.o_busy, 0);
        check("async reset done", bus.o_done, 0);
        check("async reset hi", bus.o_hi, 0);
        check("async reset lo", bus.o_lo, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) dones++;
        end
        check("no done after reset", dones, 0);
        check("lo after reset", bus.o_lo, 0);

        bus.i_lo_we = 1'b1; bus.i_lo_wdata = 32'hCAFE;
        @(negedge clk);
        bus.i_lo_we = 1'b0;
        check("mtlo after reset", bus.o_lo, 32'hCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
